// File: rtl/reg_file_wb_if.sv
// Write-back / read / dump bundle for the register file.
// master: pipeline + debug side; slave: reg_file_wb.
interface reg_file_wb_if #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
);
  logic               i_RegWrite;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_REG-1:0]  i_wr_data;
  logic [NB_ADDR-1:0] i_rs_addr;
  logic [NB_ADDR-1:0] i_rt_addr;
  logic [NB_REG-1:0]  o_rs_data;
  logic [NB_REG-1:0]  o_rt_data;
  logic               i_dump_start;
  logic               i_dump_ready;
  logic               o_dump_valid;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic [NB_REG-1:0]  o_dump_data;
  logic               o_dump_busy;
  logic               o_dump_done;

  modport master (
    output i_RegWrite, i_wr_addr, i_wr_data,
    output i_rs_addr, i_rt_addr,
    input  o_rs_data, o_rt_data,
    output i_dump_start, i_dump_ready,
    input  o_dump_valid, o_dump_addr, o_dump_data,
    input  o_dump_busy, o_dump_done
  );

  modport slave (
    input  i_RegWrite, i_wr_addr, i_wr_data,
    input  i_rs_addr, i_rt_addr,
    output o_rs_data, o_rt_data,
    input  i_dump_start, i_dump_ready,
    output o_dump_valid, o_dump_addr, o_dump_data,
    output o_dump_busy, o_dump_done
  );
endinterface

// File: rtl/reg_file_wb.sv
// MIPS register file with write-through read ports and a dump engine.
// Ports: i_clk, i_rst (async, high) and the reg_file_wb_if slave bundle.
module reg_file_wb #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic           i_clk,
  input  logic           i_rst,
  reg_file_wb_if.slave   bus
);
  localparam int N = 2 ** NB_ADDR;
  localparam logic [NB_ADDR-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  logic [NB_REG-1:0]  regs [N];
  state_t             state;
  logic [NB_ADDR-1:0] idx;
  logic               valid;
  logic               busy;
  logic               done;
  logic               wr_en;

  assign wr_en = bus.i_RegWrite && (bus.i_wr_addr != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Bypass lets ID see a value written in this same cycle.
  always_comb begin
    bus.o_rs_data = regs[bus.i_rs_addr];
    if (bus.i_rs_addr == '0)
      bus.o_rs_data = '0;
    else if (wr_en && bus.i_rs_addr == bus.i_wr_addr)
      bus.o_rs_data = bus.i_wr_data;
  end

  always_comb begin
    bus.o_rt_data = regs[bus.i_rt_addr];
    if (bus.i_rt_addr == '0)
      bus.o_rt_data = '0;
    else if (wr_en && bus.i_rt_addr == bus.i_wr_addr)
      bus.o_rt_data = bus.i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      idx   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.i_dump_start) begin
            state <= SEND;
            idx   <= '0;
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (bus.i_dump_ready) begin
            if (idx == LAST) begin
              state <= DONE;
              idx   <= '0;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // idx is 0 outside SEND and regs[0] is 0, so addr/data idle at 0.
  // Data reads the stored array so it tracks writes to regs[idx].
  assign bus.o_dump_valid = valid;
  assign bus.o_dump_busy  = busy;
  assign bus.o_dump_done  = done;
  assign bus.o_dump_addr  = idx;
  assign bus.o_dump_data  = regs[idx];
endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: random + directed traffic.
// Reference model is a plain array plus queues of expected dump words.
module tb_reg_file_wb;
  localparam int NR = 32;
  localparam int NA = 5;
  localparam int N  = 32;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_wb_if #(.NB_REG(NR), .NB_ADDR(NA)) bus();

  reg_file_wb #(.NB_REG(NR), .NB_ADDR(NA)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [N];
  int          addrq [$];
  rd_t         rdq [$];
  bit          m_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int a, input bit we,
                                         input int wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && a == wa) return wd;
    return mdl[a];
  endfunction

  task automatic cyc(input bit we, input int wa, input logic [31:0] wd,
                     input int ra, input int rb, input bit st, input bit rdy);
    bit acc;
    @(negedge clk);
    bus.i_RegWrite   = we;
    bus.i_wr_addr    = 5'(wa);
    bus.i_wr_data    = wd;
    bus.i_rs_addr    = 5'(ra);
    bus.i_rt_addr    = 5'(rb);
    bus.i_dump_start = st;
    bus.i_dump_ready = rdy;
    rdq.push_back('{exp_rd(ra, we, wa, wd), exp_rd(rb, we, wa, wd)});
    acc = st && !m_busy;
    @(posedge clk);
    if (we && wa != 0) mdl[wa] = wd;
    if (acc) begin
      m_busy = 1'b1;
      for (int k = 0; k < N; k++) addrq.push_back(k);
    end
  endtask

  task automatic idle(input bit st, input bit rdy);
    cyc(1'b0, 0, 32'h0, 5, 31, st, rdy);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 200) begin
      idle(1'b0, 1'b1);
      n++;
    end
    if (m_busy) begin
      tests++;
      fails++;
      $display("FAIL dump_timeout: busy after %0d cycles", n);
    end
  endtask

  task automatic check_zero_out(input string nm);
    chk({nm, "_valid"}, 32'(bus.o_dump_valid), 32'h0);
    chk({nm, "_busy"}, 32'(bus.o_dump_busy), 32'h0);
    chk({nm, "_done"}, 32'(bus.o_dump_done), 32'h0);
    chk({nm, "_addr"}, 32'(bus.o_dump_addr), 32'h0);
    chk({nm, "_data"}, bus.o_dump_data, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    rdq.delete();
    addrq.delete();
    m_busy = 1'b0;
    for (int k = 0; k < N; k++) mdl[k] = 32'h0;
    bus.i_RegWrite   = 1'b0;
    bus.i_dump_start = 1'b0;
    bus.i_rs_addr    = 5'd12;
    bus.i_rt_addr    = 5'd31;
    #1;
    check_zero_out("rst");
    chk("rst_rs", bus.o_rs_data, 32'h0);
    chk("rst_rt", bus.o_rt_data, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: sample mid-cycle, after inputs settle and before the edge.
  initial begin
    rd_t r;
    int  a;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (rdq.size() > 0) begin
          r = rdq.pop_front();
          chk("rs_data", bus.o_rs_data, r.rs);
          chk("rt_data", bus.o_rt_data, r.rt);
        end
        chk("dump_valid", 32'(bus.o_dump_valid), 32'(addrq.size() > 0));
        chk("dump_busy", 32'(bus.o_dump_busy), 32'(m_busy));
        chk("dump_done", 32'(bus.o_dump_done),
            32'(m_busy && addrq.size() == 0));
        if (bus.o_dump_valid && bus.i_dump_ready && addrq.size() > 0) begin
          a = addrq.pop_front();
          chk("dump_addr", 32'(bus.o_dump_addr), 32'(a));
          chk("dump_data", bus.o_dump_data, mdl[a]);
        end
        if (bus.o_dump_done) m_busy = 1'b0;
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] v;
    for (int k = 0; k < N; k++) mdl[k] = 32'h0;
    bus.i_RegWrite   = 1'b0;
    bus.i_wr_addr    = '0;
    bus.i_wr_data    = '0;
    bus.i_rs_addr    = 5'd5;
    bus.i_rt_addr    = 5'd31;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    #2;
    check_zero_out("por");
    chk("por_rs", bus.o_rs_data, 32'h0);
    chk("por_rt", bus.o_rt_data, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    cyc(1'b1, 7, 32'hDEADBEEF, 5, 31, 1'b0, 1'b0);
    cyc(1'b0, 0, 32'h0, 7, 0, 1'b0, 1'b0);
    cyc(1'b1, 0, 32'h12345678, 7, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 32'h0, 0, 0, 1'b0, 1'b0);
    cyc(1'b1, 9, 32'hA5A5A5A5, 9, 9, 1'b0, 1'b0);
    cyc(1'b1, 0, 32'hA5A5A5A5, 0, 9, 1'b0, 1'b0);

    for (int k = 1; k < N; k++) cyc(1'b1, k, 32'(k * 4), k, 0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    n = 0;
    #1;
    while (!bus.o_dump_done && n < 100) begin
      idle(1'b0, 1'b1);
      n++;
      #1;
    end
    chk("dump_len", 32'(n), 32'd32);
    chk("done_busy", 32'(bus.o_dump_busy), 32'h1);
    idle(1'b0, 1'b1);
    #1;
    chk("post_busy", 32'(bus.o_dump_busy), 32'h0);
    chk("post_done", 32'(bus.o_dump_done), 32'h0);

    idle(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) idle(1'b0, 1'b1);
    cyc(1'b1, 12, 32'h55, 12, 10, 1'b1, 1'b0);
    #1;
    chk("hold_addr0", 32'(bus.o_dump_addr), 32'd10);
    chk("hold_valid0", 32'(bus.o_dump_valid), 32'h1);
    chk("hold_data0", bus.o_dump_data, mdl[10]);
    v = $urandom;
    cyc(1'b1, 10, v, 10, 12, 1'b0, 1'b0);
    #1;
    chk("hold_addr1", 32'(bus.o_dump_addr), 32'd10);
    chk("hold_track", bus.o_dump_data, v);
    idle(1'b1, 1'b0);
    #1;
    chk("hold_addr2", 32'(bus.o_dump_addr), 32'd10);
    chk("hold_valid2", 32'(bus.o_dump_valid), 32'h1);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
          $urandom, int'($urandom_range(0, N - 1)),
          int'($urandom_range(0, N - 1)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    wait_idle();

    idle(1'b1, 1'b1);
    for (int k = 0; k < 20; k++) idle(1'b0, 1'b1);
    #1;
    chk("mid_addr", 32'(bus.o_dump_addr), 32'd20);
    do_reset();
    idle(1'b1, 1'b1);
    wait_idle();
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file that terminates the write-back path of the MIPS pipeline: it accepts the final write-back data, destination and RegWrite each cycle.
- Serves two combinational read ports (rs, rt) to the ID stage, with same-cycle write-through bypass.
- Contains a dump engine. On request, it streams every register out over a valid/ready handshake to the FPGA debug unit.

Parameters:
NB_REG, 32, width of each register and of all data buses
NB_ADDR, 5, register address width; register count = 2**NB_ADDR (default 32)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst  input  1  asynchronous reset, active-high
i_RegWrite  input  1  write enable from the write-back stage
i_wr_addr  input  NB_ADDR  destination register index
i_wr_data  input  NB_REG  data to write (write-back mux output)
i_rs_addr  input  NB_ADDR  read port A index
i_rt_addr  input  NB_ADDR  read port B index
o_rs_data  output  NB_REG  read port A data
o_rt_data  output  NB_REG  read port B data
i_dump_start  input  1  request full register dump (single-cycle pulse or level)
i_dump_ready  input  1  debug unit can accept a dump word
o_dump_valid  output  1  dump word present
o_dump_addr  output  NB_ADDR  index of the current dump word
o_dump_data  output  NB_REG  value of the current dump word
o_dump_busy  output  1  dump engine not idle
o_dump_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, i_rst=1): all registers become 0 and the FSM goes to IDLE. The dump index becomes 0. o_dump_valid, o_dump_busy and o_dump_done are 0. o_dump_addr and o_dump_data are 0.
- Register 0 is hardwired to 0. A write to index 0 is discarded, and reads of index 0 always return 0, including under bypass.
- Write: at the rising edge, if i_RegWrite=1 and i_wr_addr!=0, then regs[i_wr_addr] <= i_wr_data.
- Read: combinational, zero latency.
  - If i_RegWrite=1, addr==i_wr_addr and addr!=0, the port returns i_wr_data (write-through bypass).
  - Otherwise the port returns regs[addr].
  - Both ports are independent; the same index on both ports is legal.
- Dump FSM states:
  - IDLE: o_dump_busy=0 and o_dump_valid=0. If i_dump_start=1, go to SEND with idx=0.
  - SEND: o_dump_valid=1, o_dump_busy=1, o_dump_addr=idx, o_dump_data=regs[idx]. The dump reads the stored array value, not the bypass value.
    - A transfer occurs when o_dump_valid and i_dump_ready are both 1 at a rising edge.
    - On a transfer with idx<2**NB_ADDR-1: idx increments.
    - On a transfer with idx==2**NB_ADDR-1: go to DONE and reset idx to 0.
    - With no transfer: hold idx. Addr and data stay stable, except that data tracks a write to regs[idx].
  - DONE: o_dump_done=1 for exactly one cycle, o_dump_busy=1, o_dump_valid=0. Next state is IDLE unconditionally.
- i_dump_start is ignored in SEND and DONE; a new dump requires a return to IDLE. A start that is still held in IDLE after DONE begins a new dump.
- Pipeline writes continue during a dump. A register not yet sent shows its updated value when sent; a register already sent is not resent.
- Throughput: with i_dump_ready held at 1, a dump takes 2**NB_ADDR SEND cycles plus 1 DONE cycle (33 cycles at default).
- Reset asserted mid-dump aborts immediately: outputs return to reset values and no done pulse is produced.

Test Plan:
- Reset then read: assert i_rst asynchronously, then read rs=5 and rt=31 -> both 0; all dump outputs 0.
- Write then read: write 0xDEADBEEF to reg 7. Next cycle rs=7 -> 0xDEADBEEF.
  - Write 0x12345678 to reg 0, then rt=0 -> 0.
- Bypass: same cycle, i_RegWrite=1, wr_addr=9, wr_data=0xA5A5A5A5, rs=9, rt=9 -> both 0xA5A5A5A5 before the edge.
  - Same stimulus with wr_addr=0 and rs=0 -> 0.
- Full dump: preload regs[k]=k*4 and pulse start with ready=1.
  - 32 consecutive valid words: addr 0..31, data 0,4,...,124.
  - Then exactly one cycle of done=1 and busy=1, then busy=0.
- Backpressure: during a dump, drive ready=0 for 3 cycles at idx=10 -> addr=10 and data stay stable, valid stays 1.
  - Write 0x55 to reg 12 while idx=10, then resume -> word 12 carries 0x55.
  - A start pulse during the dump has no effect.
- Reset mid-dump: assert i_rst at idx=20 -> valid, busy and done go to 0 immediately and registers go to 0.
  - After release, a new start dumps from addr 0 with all data 0.
